// File: rtl/vend_credit_if.sv
// Coin/select handshake and credit status between the coin front-end and the
// vending credit controller.
interface vend_credit_if #(
   parameter int CREDIT_W = 7
);
   logic                nickelDetected;
   logic                dimeDetected;
   logic                quarterDetected;
   logic                select;
   logic                cancel;
   logic                soldOut;
   logic                dispense;
   logic                nickelOut;
   logic                coinReject;
   logic                denied;
   logic                busy;
   logic [CREDIT_W-1:0] credit;

   modport master (
      output nickelDetected, dimeDetected, quarterDetected, select, cancel, soldOut,
      input  dispense, nickelOut, coinReject, denied, busy, credit
   );

   modport slave (
      input  nickelDetected, dimeDetected, quarterDetected, select, cancel, soldOut,
      output dispense, nickelOut, coinReject, denied, busy, credit
   );
endinterface

// File: rtl/vend_credit_controller.sv
// Vending credit controller: accumulates coin credit up to a ceiling, vends at a
// fixed price and pays change back as a paced train of nickel pulses.
//
// state  | meaning
// IDLE   | accepting coins, select and cancel
// CHANGE | paying back credit one nickel per CHANGE_GAP+1 cycles
module vend_credit_controller #(
   parameter int PRICE      = 30,
   parameter int MAX_CREDIT = 95,
   parameter int CREDIT_W   = 7,
   parameter int CHANGE_GAP = 2
) (
   input  logic         clk,
   input  logic         reset,
   vend_credit_if.slave bus
);

   typedef enum logic {
      IDLE   = 1'b0,
      CHANGE = 1'b1
   } state_t;

   localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] NICKEL  = CREDIT_W'(5);
   localparam logic [3:0]          GAP_W   = 4'(CHANGE_GAP);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [3:0]          gap_q, gap_d;
   logic                dispense_q, dispense_d;
   logic                nickel_q, nickel_d;
   logic                reject_q, reject_d;
   logic                denied_q, denied_d;

   logic                coin_any;
   logic [CREDIT_W:0]   coin_value;
   logic [CREDIT_W:0]   sum;

   // One extra bit on the sum so an overflowing coin can be detected, not wrapped.
   always_comb begin
      coin_any = bus.nickelDetected | bus.dimeDetected | bus.quarterDetected;
      if (bus.nickelDetected)
         coin_value = (CREDIT_W+1)'(5);
      else if (bus.dimeDetected)
         coin_value = (CREDIT_W+1)'(10);
      else
         coin_value = (CREDIT_W+1)'(25);
      sum = {1'b0, credit_q} + coin_value;
   end

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      gap_d      = gap_q;
      dispense_d = 1'b0;
      nickel_d   = 1'b0;
      reject_d   = 1'b0;
      denied_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (coin_any) begin
               if (sum > MAX_W)
                  reject_d = 1'b1;
               else
                  credit_d = sum[CREDIT_W-1:0];
            end else if (bus.select) begin
               if (credit_q >= PRICE_W && !bus.soldOut) begin
                  dispense_d = 1'b1;
                  credit_d   = credit_q - PRICE_W;
                  gap_d      = '0;
                  if (credit_q != PRICE_W)
                     state_d = CHANGE;
               end else begin
                  denied_d = 1'b1;
               end
            end else if (bus.cancel && credit_q != '0) begin
               state_d = CHANGE;
               gap_d   = '0;
            end
         end
         CHANGE: begin
            reject_d = coin_any;
            if (gap_q == '0) begin
               nickel_d = 1'b1;
               credit_d = credit_q - NICKEL;
               gap_d    = GAP_W;
               if (credit_q == NICKEL)
                  state_d = IDLE;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         credit_q   <= '0;
         gap_q      <= '0;
         dispense_q <= 1'b0;
         nickel_q   <= 1'b0;
         reject_q   <= 1'b0;
         denied_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         gap_q      <= gap_d;
         dispense_q <= dispense_d;
         nickel_q   <= nickel_d;
         reject_q   <= reject_d;
         denied_q   <= denied_d;
      end
   end

   assign bus.dispense   = dispense_q;
   assign bus.nickelOut  = nickel_q;
   assign bus.coinReject = reject_q;
   assign bus.denied     = denied_q;
   assign bus.busy       = (state_q == CHANGE);
   assign bus.credit     = credit_q;

endmodule

// File: doc/vend_credit_controller.md
# vend_credit_controller

Parametrised vending credit controller that sits downstream of the coin detector. It consumes one-cycle nickel, dime and quarter pulses and accumulates credit up to a configurable ceiling, rejecting any coin that would exceed it. On a product select it vends at a configurable price and returns the remaining credit as a paced train of nickel-return pulses. A cancel input returns all credit without vending.

## Interface
- PRICE, 30: product price in cents; multiple of 5, range 5..MAX_CREDIT.
- MAX_CREDIT, 95: credit ceiling in cents; multiple of 5, at least PRICE.
- CREDIT_W, 7: width of the credit register; must satisfy 2**CREDIT_W > MAX_CREDIT.
- CHANGE_GAP, 2: idle cycles between consecutive nickelOut pulses; range 0..15.

Ports:
- clk  in  1  the single clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- nickelDetected  in  1  one-cycle pulse, 5-cent coin.
- dimeDetected  in  1  one-cycle pulse, 10-cent coin.
- quarterDetected  in  1  one-cycle pulse, 25-cent coin.
- select  in  1  one-cycle pulse, product request.
- cancel  in  1  one-cycle pulse, return all credit.
- soldOut  in  1  level; while 1, vending is inhibited.
- dispense  out  1  one-cycle pulse; vends one product.
- nickelOut  out  1  one-cycle pulse; returns one nickel.
- coinReject  out  1  one-cycle pulse; the coin was not credited.
- denied  out  1  one-cycle pulse; select refused.
- busy  out  1  1 while returning change.
- credit  out  CREDIT_W  current credit in cents.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset forces state IDLE, clears the gap counter, and abandons any change return in progress; the remaining credit is lost.
- States: IDLE and CHANGE. busy is 1 exactly when the state is CHANGE.
- Coin value is 5, 10 or 25. If more than one coin pulse arrives in the same cycle, priority is nickel, then dime, then quarter. Lower-priority coins in that cycle are dropped silently, with no coinReject.
- IDLE event priority per cycle: coin, then select, then cancel. Only the highest-priority event present is acted on; the others are dropped with no output.
- IDLE coin: sum = credit + value, computed at CREDIT_W+1 bits.
  - If sum > MAX_CREDIT: coinReject=1 and credit is unchanged.
  - Otherwise credit = sum.
- IDLE select:
  - If credit >= PRICE and soldOut=0: dispense=1 and credit = credit - PRICE. Go to CHANGE if the new credit is nonzero; otherwise stay in IDLE.
  - Otherwise: denied=1 and credit is unchanged.
- IDLE cancel: if credit > 0, go to CHANGE. If credit = 0, ignore it.
- CHANGE, gap counter = 0: nickelOut=1, credit -= 5, gap counter loads CHANGE_GAP. If the new credit is 0, go to IDLE on the same edge.
- CHANGE, gap counter > 0: decrement the gap counter.
- CHANGE, any coin pulse: coinReject=1, not credited. select is dropped silently; cancel is ignored.
- Invariant: credit <= MAX_CREDIT and credit is a multiple of 5 at all times.

## Timing
- Event sampled at edge k means the response is visible after edge k (one-cycle latency). dispense, coinReject and denied are high for exactly one cycle.
- Vend with change, select at edge k:
  - After edge k: dispense=1, credit holds the remainder, busy=1.
  - After edge k+1: first nickelOut pulse.
  - Subsequent nickelOut pulses occur every CHANGE_GAP+1 cycles.
- N nickels are returned in (N-1)*(CHANGE_GAP+1)+1 cycles after entering CHANGE. busy falls on the same edge as the last nickelOut pulse. The next cycle's coins and selects are handled as IDLE.
- Cancel at edge k: after edge k, busy=1 and nickelOut=0. The first nickelOut is after edge k+1.
- soldOut is sampled only together with select. A soldOut change during CHANGE has no effect.
- Reset asserted at any edge: all outputs are 0 after that edge, including mid-change and mid-pulse.

## Test plan
- Defaults. Stimulus: quarter, dime, select. Required: credit 25, then 35; dispense=1 with credit 5; one nickelOut one cycle later; credit 0; busy falls with that pulse.
- Overflow. Stimulus: three quarters, then a dime, then a quarter (95 then would be 110). Required: credit 75, then 85; the quarter raises coinReject=1 and credit stays 85.
- Denied and sold-out. Stimulus:
  - credit 25 with select: denied=1, credit stays 25.
  - credit 30 with soldOut=1 and select: denied=1, no dispense.
  - soldOut=0 and select: dispense=1, credit 0, busy stays 0.
- Cancel with CHANGE_GAP=2. Stimulus: credit 20, then cancel. Required: four nickelOut pulses at 3-cycle spacing; credit steps 15, 10, 5, 0. A dime injected mid-return raises coinReject and is not credited.
- Simultaneous and reset. Stimulus:
  - Nickel, dime and select in the same IDLE cycle: only 5 is credited, with no reject and no denied.
  - Reset asserted between the 2nd and 3rd nickelOut pulse: all outputs 0, credit 0, state IDLE.
- Parameter sweep. Stimulus: PRICE=5, MAX_CREDIT=25, CREDIT_W=5, CHANGE_GAP=0; a quarter followed by select. Required: dispense; four consecutive-cycle nickelOut pulses; credit ends at 0.
